// File: rtl/cam_ctrl.sv
// rtl/cam_ctrl.sv - sequencer and occupancy map in front of a DEPTH-entry CAM array
//
// Purpose: accepts one search/insert/read/delete request at a time and drives the
//          external CAM array. The occupancy map lives here because the array
//          cannot invalidate a word, so every array hit is masked with it.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   req_valid/req_ready/req_op       request handshake and opcode
//   req_data, req_index              key for search/insert, entry for read/delete
//   rsp_valid/rsp_ready              response handshake
//   rsp_hit, rsp_err, rsp_index,     response fields, held stable while rsp_valid
//   rsp_data
//   occ_count                        number of occupied entries
//   cam_reset                        array reset (follows reset)
//   cam_read/cam_read_index          array read strobe and entry
//   cam_write/cam_write_index/       array write strobe, entry and data
//   cam_write_data
//   cam_search/cam_search_data       array search strobe and key
//   cam_search_results               per-entry match from the array
//   cam_read_results                 per-entry read-valid from the array
//   cam_read_value                   data of the entry at cam_read_index
module cam_ctrl #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_data,
    input  logic [IDX_W-1:0] req_index,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_hit,
    output logic             rsp_err,
    output logic [IDX_W-1:0] rsp_index,
    output logic [WIDTH-1:0] rsp_data,
    output logic [IDX_W:0]   occ_count,
    output logic             cam_reset,
    output logic             cam_read,
    output logic [IDX_W-1:0] cam_read_index,
    output logic             cam_write,
    output logic [IDX_W-1:0] cam_write_index,
    output logic [WIDTH-1:0] cam_write_data,
    output logic             cam_search,
    output logic [WIDTH-1:0] cam_search_data,
    input  logic [DEPTH-1:0] cam_search_results,
    input  logic [DEPTH-1:0] cam_read_results,
    input  logic [WIDTH-1:0] cam_read_value
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WRITE, S_RESP} state_t;

    localparam logic [1:0] OP_SEARCH = 2'b00;
    localparam logic [1:0] OP_INSERT = 2'b01;
    localparam logic [1:0] OP_READ   = 2'b10;
    localparam logic [1:0] OP_DELETE = 2'b11;
    localparam logic [IDX_W:0] DEPTH_L = (IDX_W + 1)'(DEPTH);

    state_t           state_q, state_d;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] key_q;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] alloc_q, alloc_d;
    logic [DEPTH-1:0] occ_q, occ_d;
    logic [IDX_W:0]   count_q, count_d;
    logic             hit_q, hit_d, err_q, err_d;
    logic [IDX_W-1:0] rindex_q, rindex_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;

    logic [DEPTH-1:0] hits;
    logic [IDX_W-1:0] hit_idx, free_idx;
    logic             any_hit, full, idx_bad, fire;

    assign req_ready       = (state_q == S_IDLE);
    assign fire            = req_valid && req_ready;
    assign rsp_valid       = (state_q == S_RESP);
    assign rsp_hit         = hit_q;
    assign rsp_err         = err_q;
    assign rsp_index       = rindex_q;
    assign rsp_data        = rdata_q;
    assign occ_count       = count_q;
    assign cam_reset       = reset;
    assign cam_read_index  = idx_q;
    assign cam_write_index = alloc_q;
    assign cam_write_data  = key_q;
    assign cam_search_data = key_q;

    // Stale words of deleted entries still match in the array; masking removes them.
    assign hits    = cam_search_results & occ_q;
    assign any_hit = |hits;
    assign full    = &occ_q;
    assign idx_bad = ({1'b0, idx_q} >= DEPTH_L);

    // Lowest set bit of hits and lowest clear bit of occ (descending scan, last write wins).
    always_comb begin
        hit_idx  = '0;
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (hits[i])   hit_idx  = IDX_W'(i);
            if (!occ_q[i]) free_idx = IDX_W'(i);
        end
    end

    always_comb begin
        state_d    = state_q;
        occ_d      = occ_q;
        count_d    = count_q;
        alloc_d    = alloc_q;
        hit_d      = hit_q;
        err_d      = err_q;
        rindex_d   = rindex_q;
        rdata_d    = rdata_q;
        cam_read   = 1'b0;
        cam_write  = 1'b0;
        cam_search = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (fire) state_d = S_EXEC;
            end
            S_EXEC: begin
                hit_d    = 1'b0;
                err_d    = 1'b0;
                rindex_d = '0;
                rdata_d  = '0;
                state_d  = S_RESP;
                case (op_q)
                    OP_SEARCH: begin
                        cam_search = 1'b1;
                        hit_d      = any_hit;
                        rindex_d   = hit_idx;
                    end
                    OP_INSERT: begin
                        cam_search = 1'b1;
                        if (any_hit) begin
                            hit_d    = 1'b1;
                            rindex_d = hit_idx;
                        end else if (full) begin
                            err_d = 1'b1;
                        end else begin
                            alloc_d = free_idx;
                            state_d = S_WRITE;
                        end
                    end
                    OP_READ: begin
                        rindex_d = idx_q;
                        if (idx_bad) begin
                            err_d = 1'b1;
                        end else begin
                            cam_read = 1'b1;
                            hit_d    = occ_q[idx_q] & cam_read_results[idx_q];
                            rdata_d  = hit_d ? cam_read_value : '0;
                        end
                    end
                    default: begin // OP_DELETE: bookkeeping only, the array is not touched
                        rindex_d = idx_q;
                        if (idx_bad) begin
                            err_d = 1'b1;
                        end else begin
                            hit_d = occ_q[idx_q];
                            if (occ_q[idx_q]) begin
                                occ_d[idx_q] = 1'b0;
                                count_d      = count_q - 1'b1;
                            end
                        end
                    end
                endcase
            end
            S_WRITE: begin
                cam_write      = 1'b1;
                occ_d[alloc_q] = 1'b1;
                count_d        = count_q + 1'b1;
                hit_d          = 1'b0;
                rindex_d       = alloc_q;
                state_d        = S_RESP;
            end
            default: begin // S_RESP
                if (rsp_ready) state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= OP_SEARCH;
            key_q    <= '0;
            idx_q    <= '0;
            alloc_q  <= '0;
            occ_q    <= '0;
            count_q  <= '0;
            hit_q    <= 1'b0;
            err_q    <= 1'b0;
            rindex_q <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            alloc_q  <= alloc_d;
            occ_q    <= occ_d;
            count_q  <= count_d;
            hit_q    <= hit_d;
            err_q    <= err_d;
            rindex_q <= rindex_d;
            rdata_q  <= rdata_d;
            if (fire) begin
                op_q  <= req_op;
                key_q <= req_data;
                idx_q <= req_index;
            end
        end
    end

endmodule

// File: tb/tb_cam_ctrl.sv
// tb/tb_cam_ctrl.sv - scoreboard testbench for cam_ctrl with a behavioural CAM array
module tb_cam_ctrl;
    localparam int DEPTH = 16;
    localparam int WIDTH = 32;
    localparam int IDX_W = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [1:0]       req_op = 2'b00;
    logic [WIDTH-1:0] req_data = '0;
    logic [IDX_W-1:0] req_index = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b1;
    logic             rsp_hit, rsp_err;
    logic [IDX_W-1:0] rsp_index;
    logic [WIDTH-1:0] rsp_data;
    logic [IDX_W:0]   occ_count;
    logic             cam_reset, cam_read, cam_write, cam_search;
    logic [IDX_W-1:0] cam_read_index, cam_write_index;
    logic [WIDTH-1:0] cam_write_data, cam_search_data, cam_read_value;
    logic [DEPTH-1:0] cam_search_results, cam_read_results;

    cam_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_data(req_data), .req_index(req_index),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit),
        .rsp_err(rsp_err), .rsp_index(rsp_index), .rsp_data(rsp_data),
        .occ_count(occ_count), .cam_reset(cam_reset),
        .cam_read(cam_read), .cam_read_index(cam_read_index),
        .cam_write(cam_write), .cam_write_index(cam_write_index),
        .cam_write_data(cam_write_data),
        .cam_search(cam_search), .cam_search_data(cam_search_data),
        .cam_search_results(cam_search_results), .cam_read_results(cam_read_results),
        .cam_read_value(cam_read_value)
    );

    always #5 clk = ~clk;

    // Behavioural array: keeps stale words after delete, so masking is exercised.
    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] vld = '0;
    initial for (int i = 0; i < DEPTH; i++) mem[i] = '0;

    always_comb begin
        cam_search_results = '0;
        for (int i = 0; i < DEPTH; i++)
            cam_search_results[i] = vld[i] && (mem[i] == cam_search_data);
    end
    assign cam_read_results = vld;
    assign cam_read_value   = mem[cam_read_index];

    always @(posedge clk) begin
        if (cam_reset) vld <= '0;
        else if (cam_write) begin
            mem[cam_write_index] <= cam_write_data;
            vld[cam_write_index] <= 1'b1;
        end
    end

    int checks = 0;
    int failures = 0;
    int wr_cnt = 0;

    always @(negedge clk) if (cam_write) wr_cnt++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic             hit;
        logic             err;
        logic [IDX_W-1:0] index;
        logic             chk_index;
        logic [WIDTH-1:0] data;
    } exp_t;

    exp_t exp_q[$];

    // Monitor: pops one expectation per accepted response.
    always @(negedge clk) begin
        if (!reset && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp_hit", 64'(rsp_hit), 64'(e.hit));
                chk("rsp_err", 64'(rsp_err), 64'(e.err));
                if (e.chk_index) chk("rsp_index", 64'(rsp_index), 64'(e.index));
                chk("rsp_data", 64'(rsp_data), 64'(e.data));
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [WIDTH-1:0] data,
                         input logic [IDX_W-1:0] idx,
                         input logic e_hit, input logic e_err,
                         input logic [IDX_W-1:0] e_idx, input logic e_chk_idx,
                         input logic [WIDTH-1:0] e_data, input int e_lat, input int hold);
        exp_t e;
        int n;
        logic [39:0] snap;
        e.hit = e_hit; e.err = e_err; e.index = e_idx; e.chk_index = e_chk_idx; e.data = e_data;
        exp_q.push_back(e);
        @(posedge clk); #1;
        rsp_ready = (hold == 0);
        req_valid = 1'b1; req_op = op; req_data = data; req_index = idx;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 10);
        chk("latency", 64'(n), 64'(e_lat));
        if (hold > 0) begin
            snap = {rsp_valid, rsp_hit, rsp_err, rsp_index, rsp_data, 1'b0};
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                chk("hold_stable", 64'({rsp_valid, rsp_hit, rsp_err, rsp_index, rsp_data, req_ready}),
                    64'(snap));
            end
            @(posedge clk); #1;
            rsp_ready = 1'b1;
        end
        @(posedge clk);
    endtask

    localparam logic [1:0] SRCH = 2'b00, INS = 2'b01, RD = 2'b10, DEL = 2'b11;

    initial begin
        int w0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_req_ready", 64'(req_ready), 64'd1);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_occ_count", 64'(occ_count), 64'd0);
        chk("reset_strobes", 64'({cam_read, cam_write, cam_search}), 64'd0);

        issue(SRCH, 32'hDEAD_BEEF, 0, 0, 0, 0, 1, 0, 2, 0);

        issue(INS, 32'hA, 0, 0, 0, 0, 1, 0, 3, 0);
        issue(INS, 32'hB, 0, 0, 0, 1, 1, 0, 3, 0);
        issue(INS, 32'hC, 0, 0, 0, 2, 1, 0, 3, 0);
        w0 = wr_cnt;
        issue(INS, 32'hB, 0, 1, 0, 1, 1, 0, 2, 0);
        chk("dup_no_write", 64'(wr_cnt), 64'(w0));
        chk("count_after_dup", 64'(occ_count), 64'd3);

        issue(DEL, 0, 1, 1, 0, 1, 0, 0, 2, 0);
        chk("count_after_del", 64'(occ_count), 64'd2);
        issue(SRCH, 32'hB, 0, 0, 0, 0, 1, 0, 2, 0);
        issue(INS, 32'hD, 0, 0, 0, 1, 1, 0, 3, 0);

        for (int i = 3; i < DEPTH; i++)
            issue(INS, 32'h100 + i, 0, 0, 0, IDX_W'(i), 1, 0, 3, 0);
        chk("count_full", 64'(occ_count), 64'(DEPTH));
        w0 = wr_cnt;
        issue(INS, 32'h999, 0, 0, 1, 0, 0, 0, 2, 0);
        chk("full_no_write", 64'(wr_cnt), 64'(w0));
        issue(RD, 0, 5, 1, 0, 5, 1, 32'h105, 2, 0);
        issue(SRCH, 32'hD, 0, 1, 0, 1, 1, 0, 2, 0);

        issue(RD, 0, 7, 1, 0, 7, 1, 32'h107, 2, 10);
        issue(DEL, 0, 3, 1, 0, 3, 0, 0, 2, 0);
        issue(DEL, 0, 3, 0, 0, 3, 0, 0, 2, 0);
        chk("count_after_del3", 64'(occ_count), 64'(DEPTH - 1));

        // Reset while the controller sits in WRITE for a new insert.
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = INS; req_data = 32'h555;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("in_write_state", 64'(cam_write), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_occ_count", 64'(occ_count), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd1);

        issue(SRCH, 32'hA, 0, 0, 0, 0, 1, 0, 2, 0);
        repeat (3) @(posedge clk);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
